// File: rtl/jtframe_68kbusarb_pkg.sv
// Shared definitions for the 68000 bus arbiter.
//   - 3-bit state encoding
//   - next_winner(): 2-way round-robin tie-break
package jtframe_68karb_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT_AS = 3'd2;
  localparam logic [2:0] ST_OWN     = 3'd3;
  localparam logic [2:0] ST_REL     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    REQ     = ST_REQ,
    WAIT_AS = ST_WAIT_AS,
    OWN     = ST_OWN,
    REL     = ST_REL
  } arb_st_t;

  // A lone requester wins; on a tie the master not served last wins.
  // With no request the result is unused, so keep it stable at 'last'.
  function automatic logic next_winner(input logic [1:0] req, input logic last);
    case (req)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~last;
      default: return last;
    endcase
  endfunction

endpackage

// File: rtl/jtframe_68kbusarb_if.sv
// Bus-arbitration handshake bundle.
//   slave  : arbiter side (takes CPU ASn/BGn and master req/done, drives
//            BRn/BGACKn to the CPU and gnt/dma_legit/busy to the masters)
//   master : environment side (CPU + DMA masters)
interface jtframe_68kbusarb_if;
  logic       ASn;
  logic       BGn;
  logic       BRn;
  logic       BGACKn;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       dma_legit;
  logic       busy;

  modport slave  (input  ASn, BGn, req, done,
                  output BRn, BGACKn, gnt, dma_legit, busy);
  modport master (output ASn, BGn, req, done,
                  input  BRn, BGACKn, gnt, dma_legit, busy);
endinterface

// File: rtl/jtframe_68kbusarb_rr.sv
// Combinational 2-way round-robin picker.
//   req  : request vector
//   last : index of the master served last
//   win  : index of the selected master (valid when any=1)
//   any  : at least one request pending
module jtframe_68karb_rr
  import jtframe_68karb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       any
);

  assign win = next_winner(req, last);
  assign any = |req;

endmodule

// File: rtl/jtframe_68kbusarb.sv
// 68000 bus arbiter for two DMA masters using BRn/BGn/BGACKn.
//   clk, rst_n : clock, asynchronous active-low reset
//   cpu_cen    : CPU clock enable; the FSM only moves on these edges
//   bus        : handshake bundle (slave side), see jtframe_68kbusarb_if
// Parameters:
//   MAXCEN : max tenure in cpu_cen ticks per grant, 0 = unlimited
//   CW     : tenure counter width (MAXCEN < 2**CW)
module jtframe_68kbusarb
  import jtframe_68karb_pkg::*;
#(
  parameter int MAXCEN = 0,
  parameter int CW     = 8
)(
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_cen,
  jtframe_68kbusarb_if.slave bus
);

  // Counter starts at 0 on the grant edge, so the last allowed tick sees MAXCEN-1
  localparam logic [CW-1:0] LIM = CW'(MAXCEN == 0 ? 0 : MAXCEN - 1);

  arb_st_t       st_q, st_nx;
  logic          win_q, win_nx;
  logic          last_q, last_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic          brn_q, brn_nx;
  logic          bgackn_q, bgackn_nx;
  logic [1:0]    gnt_q, gnt_nx;
  logic          legit_q, legit_nx;
  logic          busy_q, busy_nx;

  logic rr_win, rr_any, lim_hit;

  jtframe_68karb_rr u_rr (
    .req  (bus.req),
    .last (last_q),
    .win  (rr_win),
    .any  (rr_any)
  );

  assign lim_hit = (MAXCEN != 0) && (cnt_q == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      brn_q    <= 1'b1;
      bgackn_q <= 1'b1;
      gnt_q    <= 2'b00;
      legit_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      st_q     <= st_nx;
      win_q    <= win_nx;
      last_q   <= last_nx;
      cnt_q    <= cnt_nx;
      brn_q    <= brn_nx;
      bgackn_q <= bgackn_nx;
      gnt_q    <= gnt_nx;
      legit_q  <= legit_nx;
      busy_q   <= busy_nx;
    end
  end

  always_comb begin
    st_nx     = st_q;
    win_nx    = win_q;
    last_nx   = last_q;
    cnt_nx    = cnt_q;
    brn_nx    = brn_q;
    bgackn_nx = bgackn_q;
    gnt_nx    = gnt_q;
    legit_nx  = legit_q;
    if (cpu_cen) begin
      case (st_q)
        IDLE: if (rr_any) begin
          win_nx = rr_win;
          brn_nx = 1'b0;
          st_nx  = REQ;
        end
        REQ: begin
          // A winner that gives up before the grant aborts the request
          if (!bus.req[win_q]) begin
            brn_nx = 1'b1;
            st_nx  = IDLE;
          end else if (!bus.BGn) begin
            st_nx = WAIT_AS;
          end
        end
        // Take the bus only once the CPU's current cycle has ended
        WAIT_AS: if (bus.ASn) begin
          bgackn_nx = 1'b0;
          brn_nx    = 1'b1;
          gnt_nx    = win_q ? 2'b10 : 2'b01;
          legit_nx  = 1'b1;
          cnt_nx    = '0;
          st_nx     = OWN;
        end
        OWN: begin
          cnt_nx = cnt_q + CW'(1);
          if (bus.done[win_q] || !bus.req[win_q] || lim_hit) begin
            gnt_nx    = 2'b00;
            legit_nx  = 1'b0;
            bgackn_nx = 1'b1;
            last_nx   = win_q;
            st_nx     = REL;
          end
        end
        // One tick with BGACKn high before arbitrating again
        REL:     st_nx = IDLE;
        default: st_nx = IDLE;
      endcase
    end
    busy_nx = (st_nx != IDLE);
  end

  assign bus.BRn       = brn_q;
  assign bus.BGACKn    = bgackn_q;
  assign bus.gnt       = gnt_q;
  assign bus.dma_legit = legit_q;
  assign bus.busy      = busy_q;

endmodule
